// File: rtl/fantasticfft_fft8_loader.sv
// fantasticfft_fft8_loader
//   Input-side frame loader for the 8-point FFT core. Collects a serial
//   valid/ready stream of complex fixed-point samples into an 8-slot frame
//   buffer, optionally in bit-reversed slot order, then holds the whole
//   frame in parallel until the FFT core takes it. Frames that end early
//   (s_last before the 8th sample) or run long (no s_last on the 8th
//   sample) raise a one-cycle error pulse.
//
// Ports
//   clk          single clock, all logic on posedge
//   rst          synchronous active-high reset
//   s_valid      input sample valid
//   s_ready      loader can accept a sample (low during rst and PRESENT)
//   s_re, s_im   sample real / imaginary part, two's complement
//   s_last       marks the final sample of a frame
//   frame_valid  full frame held on frame_re / frame_im
//   frame_ready  FFT core accepts the frame
//   frame_re     slot j at frame_re[W*j +: W]
//   frame_im     slot j at frame_im[W*j +: W]
//   err_short    1-cycle pulse: s_last arrived before the 8th sample
//   err_long     1-cycle pulse: 8th sample arrived without s_last
module fantasticfft_fft8_loader #(
  parameter int INT_BITS    = 8,
  parameter int FRAC_BITS   = 8,
  parameter int BIT_REVERSE = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [INT_BITS+FRAC_BITS-1:0]        s_re,
  input  logic [INT_BITS+FRAC_BITS-1:0]        s_im,
  input  logic                                 s_last,
  output logic                                 frame_valid,
  input  logic                                 frame_ready,
  output logic [8*(INT_BITS+FRAC_BITS)-1:0]    frame_re,
  output logic [8*(INT_BITS+FRAC_BITS)-1:0]    frame_im,
  output logic                                 err_short,
  output logic                                 err_long
);

  localparam int W = INT_BITS + FRAC_BITS;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DRAIN   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [2:0]   cnt_reg, cnt_next;
  logic         err_short_reg, err_short_next;
  logic         err_long_reg, err_long_next;
  logic         wr_en;
  logic [2:0]   wr_slot;
  logic         beat;

  // Ready depends only on registered state (and rst), never on s_valid.
  assign s_ready     = !rst && (state_reg != PRESENT);
  assign beat        = s_valid && s_ready;
  assign frame_valid = (state_reg == PRESENT);
  assign err_short   = err_short_reg;
  assign err_long    = err_long_reg;

  generate
    if (BIT_REVERSE != 0) begin : g_bitrev
      assign wr_slot = {cnt_reg[0], cnt_reg[1], cnt_reg[2]};
    end else begin : g_natural
      assign wr_slot = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      cnt_reg       <= 3'd0;
      err_short_reg <= 1'b0;
      err_long_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      err_short_reg <= err_short_next;
      err_long_reg  <= err_long_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    err_short_next = 1'b0;
    err_long_next  = 1'b0;
    wr_en          = 1'b0;
    case (state_reg)
      FILL: begin
        if (beat) begin
          wr_en = 1'b1;
          if (cnt_reg == 3'd7) begin
            cnt_next = 3'd0;
            if (s_last) begin
              state_next = PRESENT;
            end else begin
              err_long_next = 1'b1;
              state_next    = DRAIN;
            end
          end else if (s_last) begin
            // Short frame: abandon it; stale slot contents get overwritten
            // by the next complete frame.
            err_short_next = 1'b1;
            cnt_next       = 3'd0;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end
      DRAIN: begin
        // Swallow the excess samples of a long frame; buffer untouched.
        if (beat && s_last) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (frame_ready) begin
          state_next = FILL;
          cnt_next   = 3'd0;
        end
      end
      default: begin
        state_next = FILL;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // One register pair per slot so the whole frame is readable in parallel.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      logic [W-1:0] re_reg;
      logic [W-1:0] im_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          re_reg <= '0;
          im_reg <= '0;
        end else if (wr_en && (wr_slot == 3'(gi))) begin
          re_reg <= s_re;
          im_reg <= s_im;
        end
      end

      assign frame_re[W*gi +: W] = re_reg;
      assign frame_im[W*gi +: W] = im_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fantasticfft_fft8_loader.sv
// Directed testbench for fantasticfft_fft8_loader. Two instances share all
// inputs: one stores in bit-reversed order, the other in natural order, so
// every scenario checks both slot mappings.
module tb_fantasticfft_fft8_loader;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_valid = 1'b0;
  logic [W-1:0]   s_re = '0;
  logic [W-1:0]   s_im = '0;
  logic           s_last = 1'b0;
  logic           frame_ready = 1'b0;

  logic           s_ready_br, s_ready_nat;
  logic           fv_br, fv_nat;
  logic [8*W-1:0] fre_br, fre_nat, fim_br, fim_nat;
  logic           es_br, es_nat, el_br, el_nat;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected frames, written out slot 7 down to slot 0.
  localparam logic [8*W-1:0] EXP_K_BR  = {16'h0700, 16'h0300, 16'h0500, 16'h0100,
                                          16'h0600, 16'h0200, 16'h0400, 16'h0000};
  localparam logic [8*W-1:0] EXP_K_NAT = {16'h0700, 16'h0600, 16'h0500, 16'h0400,
                                          16'h0300, 16'h0200, 16'h0100, 16'h0000};
  localparam logic [8*W-1:0] EXP_B5    = {8{16'h00B5}};
  localparam logic [8*W-1:0] EXP_A_BR  = {16'hA007, 16'hA003, 16'hA005, 16'hA001,
                                          16'hA006, 16'hA002, 16'hA004, 16'hA000};
  localparam logic [8*W-1:0] EXP_A_NAT = {16'hA007, 16'hA006, 16'hA005, 16'hA004,
                                          16'hA003, 16'hA002, 16'hA001, 16'hA000};
  localparam logic [8*W-1:0] EXP_F_BR  = {16'h0F07, 16'h0F03, 16'h0F05, 16'h0F01,
                                          16'h0F06, 16'h0F02, 16'h0F04, 16'h0F00};
  localparam logic [8*W-1:0] EXP_F_NAT = {16'h0F07, 16'h0F06, 16'h0F05, 16'h0F04,
                                          16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00};

  fantasticfft_fft8_loader #(.INT_BITS(8), .FRAC_BITS(8), .BIT_REVERSE(1)) dut_br (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready_br), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .frame_valid(fv_br), .frame_ready(frame_ready), .frame_re(fre_br), .frame_im(fim_br),
    .err_short(es_br), .err_long(el_br)
  );

  fantasticfft_fft8_loader #(.INT_BITS(8), .FRAC_BITS(8), .BIT_REVERSE(0)) dut_nat (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready_nat), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .frame_valid(fv_nat), .frame_ready(frame_ready), .frame_re(fre_nat), .frame_im(fim_nat),
    .err_short(es_nat), .err_long(el_nat)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One input beat: drive, clock it in, then drop s_valid.
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    s_valid = 1'b1;
    s_re    = re;
    s_im    = im;
    s_last  = last;
    step();
    $display("[%0t] beat re=%h im=%h last=%0d", $time, re, im, last);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({s_ready_br, s_ready_nat} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_s_ready cycle %0d: got %b want 00", i, {s_ready_br, s_ready_nat});
      end
      n_checks++;
      if ({fv_br, fv_nat, es_br, es_nat, el_br, el_nat} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_flags cycle %0d: got %b want 000000", i,
                 {fv_br, fv_nat, es_br, es_nat, el_br, el_nat});
      end
    end
    n_checks++;
    if ({fre_br, fim_br, fre_nat, fim_nat} !== '0) begin
      n_fail++;
      $display("FAIL reset_buffers: got %h %h want 0", fre_br, fre_nat);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({s_ready_br, s_ready_nat, fv_br, fv_nat} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release: got ready/fv %b want 1100", {s_ready_br, s_ready_nat, fv_br, fv_nat});
    end
    $display("[%0t] reset released", $time);
  endtask

  task automatic test_basic();
    frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(16'(k << 8), 16'h00B5, k == 7);
      if (k == 6) begin
        n_checks++;
        if ({fv_br, fv_nat} !== 2'b00) begin
          n_fail++;
          $display("FAIL basic_early_fv: got %b want 00", {fv_br, fv_nat});
        end
      end
    end
    n_checks++;
    if ({fv_br, fv_nat} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_fv: got %b want 11", {fv_br, fv_nat});
    end
    n_checks++;
    if (fre_br !== EXP_K_BR) begin
      n_fail++;
      $display("FAIL basic_re_bitrev: got %h want %h", fre_br, EXP_K_BR);
    end
    n_checks++;
    if (fre_nat !== EXP_K_NAT) begin
      n_fail++;
      $display("FAIL basic_re_natural: got %h want %h", fre_nat, EXP_K_NAT);
    end
    n_checks++;
    if ({fim_br, fim_nat} !== {EXP_B5, EXP_B5}) begin
      n_fail++;
      $display("FAIL basic_im: got %h %h want %h", fim_br, fim_nat, EXP_B5);
    end
    $display("[%0t] basic frame presented re=%h", $time, fre_br);
    step();
    n_checks++;
    if ({fv_br, fv_nat, s_ready_br, s_ready_nat} !== 4'b0011) begin
      n_fail++;
      $display("FAIL basic_handoff: got fv/ready %b want 0011", {fv_br, fv_nat, s_ready_br, s_ready_nat});
    end
    frame_ready = 1'b0;
  endtask

  task automatic test_stall();
    frame_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(16'(k << 8), 16'h00B5, k == 7);
    // Source keeps pushing junk while the frame is held; none of it may land.
    s_valid = 1'b1;
    s_re    = 16'hFFFF;
    s_im    = 16'hFFFF;
    s_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({s_ready_br, s_ready_nat, fv_br, fv_nat} !== 4'b0011) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got ready/fv %b want 0011", i,
                 {s_ready_br, s_ready_nat, fv_br, fv_nat});
      end
      n_checks++;
      if ({fre_br, fre_nat, fim_br} !== {EXP_K_BR, EXP_K_NAT, EXP_B5}) begin
        n_fail++;
        $display("FAIL stall_data cycle %0d: got %h %h want %h %h", i, fre_br, fre_nat, EXP_K_BR, EXP_K_NAT);
      end
      step();
    end
    s_valid     = 1'b0;
    s_last      = 1'b0;
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    n_checks++;
    if ({fv_br, fv_nat, s_ready_br, s_ready_nat} !== 4'b0011) begin
      n_fail++;
      $display("FAIL stall_release: got fv/ready %b want 0011", {fv_br, fv_nat, s_ready_br, s_ready_nat});
    end
    n_checks++;
    if (fre_br !== EXP_K_BR) begin
      n_fail++;
      $display("FAIL stall_after_release: got %h want %h", fre_br, EXP_K_BR);
    end
    $display("[%0t] stalled frame released", $time);
  endtask

  task automatic test_long();
    frame_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) send(16'hA000 | 16'(k), 16'h0F00 | 16'(k), 1'b0);
      else       send(16'hDEAD, 16'hBEEF, k == 9);
      if (k == 7) begin
        n_checks++;
        if ({el_br, el_nat, es_br, es_nat, fv_br, fv_nat} !== 6'b110000) begin
          n_fail++;
          $display("FAIL long_err_pulse: got el/es/fv %b want 110000",
                   {el_br, el_nat, es_br, es_nat, fv_br, fv_nat});
        end
      end
      if (k == 8) begin
        n_checks++;
        if ({el_br, el_nat, fv_br, fv_nat, s_ready_br, s_ready_nat} !== 6'b000011) begin
          n_fail++;
          $display("FAIL long_drain: got el/fv/ready %b want 000011",
                   {el_br, el_nat, fv_br, fv_nat, s_ready_br, s_ready_nat});
        end
      end
    end
    n_checks++;
    if ({fv_br, fv_nat} !== 2'b11) begin
      n_fail++;
      $display("FAIL long_fv: got %b want 11", {fv_br, fv_nat});
    end
    n_checks++;
    if ({fre_br, fim_br} !== {EXP_A_BR, EXP_F_BR}) begin
      n_fail++;
      $display("FAIL long_data_bitrev: got %h %h want %h %h", fre_br, fim_br, EXP_A_BR, EXP_F_BR);
    end
    n_checks++;
    if ({fre_nat, fim_nat} !== {EXP_A_NAT, EXP_F_NAT}) begin
      n_fail++;
      $display("FAIL long_data_natural: got %h %h want %h %h", fre_nat, fim_nat, EXP_A_NAT, EXP_F_NAT);
    end
    $display("[%0t] long frame presented re=%h", $time, fre_br);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  task automatic test_short();
    for (int k = 0; k < 3; k++) send(16'h5555, 16'h5555, k == 2);
    n_checks++;
    if ({es_br, es_nat, el_br, el_nat, fv_br, fv_nat} !== 6'b110000) begin
      n_fail++;
      $display("FAIL short_err_pulse: got es/el/fv %b want 110000",
               {es_br, es_nat, el_br, el_nat, fv_br, fv_nat});
    end
    step();
    n_checks++;
    if ({es_br, es_nat, fv_br, fv_nat} !== 4'b0000) begin
      n_fail++;
      $display("FAIL short_pulse_width: got es/fv %b want 0000", {es_br, es_nat, fv_br, fv_nat});
    end
    for (int k = 0; k < 8; k++) send(16'(k << 8), 16'h00B5, k == 7);
    n_checks++;
    if ({fv_br, fv_nat, el_br, el_nat, es_br, es_nat} !== 6'b110000) begin
      n_fail++;
      $display("FAIL short_next_fv: got fv/el/es %b want 110000",
               {fv_br, fv_nat, el_br, el_nat, es_br, es_nat});
    end
    n_checks++;
    if ({fre_br, fre_nat, fim_br, fim_nat} !== {EXP_K_BR, EXP_K_NAT, EXP_B5, EXP_B5}) begin
      n_fail++;
      $display("FAIL short_next_data: got %h %h want %h %h", fre_br, fre_nat, EXP_K_BR, EXP_K_NAT);
    end
    $display("[%0t] frame after short presented re=%h", $time, fre_br);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) send(16'h3333, 16'h3333, 1'b0);
    rst = 1'b1;
    step();
    n_checks++;
    if ({s_ready_br, s_ready_nat, fv_br, fv_nat, es_br, es_nat, el_br, el_nat} !== 8'b0) begin
      n_fail++;
      $display("FAIL midrst_during: got ready/fv/es/el %b want 00000000",
               {s_ready_br, s_ready_nat, fv_br, fv_nat, es_br, es_nat, el_br, el_nat});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({s_ready_br, s_ready_nat, es_br, es_nat, el_br, el_nat} !== 6'b110000) begin
      n_fail++;
      $display("FAIL midrst_after: got ready/es/el %b want 110000",
               {s_ready_br, s_ready_nat, es_br, es_nat, el_br, el_nat});
    end
    n_checks++;
    if ({fre_br, fre_nat, fim_br, fim_nat} !== '0) begin
      n_fail++;
      $display("FAIL midrst_cleared: got %h %h want 0", fre_br, fre_nat);
    end
    for (int k = 0; k < 8; k++) begin
      send(16'(k << 8), 16'h00B5, k == 7);
      n_checks++;
      if ({es_br, es_nat, el_br, el_nat} !== 4'b0000) begin
        n_fail++;
        $display("FAIL midrst_no_err beat %0d: got %b want 0000", k, {es_br, es_nat, el_br, el_nat});
      end
    end
    n_checks++;
    if ({fv_br, fv_nat} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_fv: got %b want 11", {fv_br, fv_nat});
    end
    n_checks++;
    if (fre_nat !== EXP_K_NAT) begin
      n_fail++;
      $display("FAIL midrst_natural: got %h want %h", fre_nat, EXP_K_NAT);
    end
    n_checks++;
    if (fre_br !== EXP_K_BR) begin
      n_fail++;
      $display("FAIL midrst_bitrev: got %h want %h", fre_br, EXP_K_BR);
    end
    $display("[%0t] frame after mid reset presented re=%h", $time, fre_nat);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_long();
    test_short();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
